reg_test_checker: RTL and testbench

Synthesizable self-checking register-file comparator for on-FPGA instruction regression. It holds a programmable expected register image with a per-register care mask and waits a programmable run length (or an early halt from the core). It then scans the register file of one or more cores through a read port and reports pass/fail, mismatch count and first failing index per core. It sits beside `RISC_V_Core` instances in the test top and replaces the hierarchical-reference comparison used by simulation-only benches.

---
 rtl/reg_test_pkg.sv | 21 ++
 rtl/reg_test_expect_mem.sv | 44 ++++
 rtl/reg_test_checker.sv | 168 ++++++++++++++++
 tb/tb_reg_test_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_test_pkg.sv
// Shared types and reset constants for the register-file regression checker.
package reg_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Expected image comes out of reset as all-zero values, every register compared.
  localparam logic EXP_DATA_RST_BIT = 1'b0;
  localparam logic EXP_CARE_RST     = 1'b1;

  // Commands (run start, image writes) are only honoured while no run is in flight.
  function automatic logic cmd_accept(input state_e st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/reg_test_expect_mem.sv
// Expected register image plus per-register care bit; one write port, one async read port.
module reg_test_expect_mem
  import reg_test_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_BITS   = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [IDX_BITS-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_care_i,
  input  logic [IDX_BITS-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_care_o
);

  localparam logic [IDX_BITS:0] NUM_REGS_W = NUM_REGS[IDX_BITS:0];

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [NUM_REGS-1:0]   care_q;
  logic                  wr_ok;

  // Indices past the end of a non-power-of-two image are silently dropped.
  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < NUM_REGS_W);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= {DATA_WIDTH{EXP_DATA_RST_BIT}};
      end
      care_q <= {NUM_REGS{EXP_CARE_RST}};
    end else if (wr_ok) begin
      data_q[wr_addr_i] <= wr_data_i;
      care_q[wr_addr_i] <= wr_care_i;
    end
  end

  assign rd_data_o = data_q[rd_addr_i];
  assign rd_care_o = care_q[rd_addr_i];

endmodule

// File: rtl/reg_test_checker.sv
// Waits a programmable run length (or core halt), scans each core's register file and
// compares it against the expected image, reporting pass, mismatch count and first failing index.
module reg_test_checker
  import reg_test_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_BITS   = $clog2(NUM_REGS),
  parameter int NUM_CORES  = 1,
  parameter int LEN_BITS   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [LEN_BITS-1:0]               test_length,
  input  logic                              halt_in,
  input  logic                              exp_we,
  input  logic [IDX_BITS-1:0]               exp_addr,
  input  logic [DATA_WIDTH-1:0]             exp_data,
  input  logic                              exp_care,
  output logic                              rf_read_en,
  output logic [IDX_BITS-1:0]               rf_read_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   rf_read_data,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_CORES-1:0]              pass,
  output logic [NUM_CORES*(IDX_BITS+1)-1:0] fail_count,
  output logic [NUM_CORES*IDX_BITS-1:0]     first_fail
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   scan_idx_q, scan_idx_d;
  logic                  done_q, done_d;
  logic                  cmp_vld_q;
  logic [IDX_BITS-1:0]   cmp_idx_q;
  logic                  cmd_ok;
  logic                  start_acc;
  logic [DATA_WIDTH-1:0] exp_val;
  logic                  exp_cmp_care;

  assign cmd_ok    = cmd_accept(state_q);
  assign start_acc = start && cmd_ok;

  reg_test_expect_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_BITS   (IDX_BITS)
  ) u_expect_mem (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (exp_we && cmd_ok),
    .wr_addr_i (exp_addr),
    .wr_data_i (exp_data),
    .wr_care_i (exp_care),
    .rd_addr_i (cmp_idx_q),
    .rd_data_o (exp_val),
    .rd_care_o (exp_cmp_care)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_idx_d = scan_idx_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_WAIT;
          cnt_d      = test_length;
          scan_idx_d = '0;
          done_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if ((cnt_q == '0) || halt_in) begin
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_idx_q == LAST_IDX) begin
          state_d    = ST_DRAIN;
          scan_idx_d = '0;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_idx_q <= scan_idx_d;
      done_q     <= done_d;
    end
  end

  assign rf_read_en   = (state_q == ST_SCAN);
  assign rf_read_addr = scan_idx_q;
  assign busy         = (state_q == ST_WAIT) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done         = done_q;

  // Read data arrives one cycle after the strobe, so the index travels alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
    end else begin
      cmp_vld_q <= rf_read_en;
      cmp_idx_q <= rf_read_addr;
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    logic [IDX_BITS:0]   fail_cnt_q, fail_cnt_d;
    logic [IDX_BITS-1:0] first_fail_q, first_fail_d;
    logic                mismatch;

    assign mismatch = cmp_vld_q && exp_cmp_care &&
                      (rf_read_data[k*DATA_WIDTH +: DATA_WIDTH] != exp_val);

    always_comb begin
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      if (start_acc) begin
        fail_cnt_d   = '0;
        first_fail_d = '0;
      end else if (mismatch) begin
        fail_cnt_d = fail_cnt_q + 1'b1;
        // Scan order is ascending, so the first hit is the lowest failing index.
        if (fail_cnt_q == '0) begin
          first_fail_d = cmp_idx_q;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        fail_cnt_q   <= '0;
        first_fail_q <= '0;
      end else begin
        fail_cnt_q   <= fail_cnt_d;
        first_fail_q <= first_fail_d;
      end
    end

    assign pass[k]                                = done_q && (fail_cnt_q == '0);
    assign fail_count[k*(IDX_BITS+1) +: IDX_BITS+1] = fail_cnt_q;
    assign first_fail[k*IDX_BITS +: IDX_BITS]       = first_fail_q;
  end

endmodule

// File: tb/tb_reg_test_checker.sv
// Directed bench for reg_test_checker with two cores; register files modelled as arrays.
module tb_reg_test_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IB = 5;
  localparam int NC = 2;
  localparam int LB = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [LB-1:0]     test_length;
  logic              halt_in;
  logic              exp_we;
  logic [IB-1:0]     exp_addr;
  logic [DW-1:0]     exp_data;
  logic              exp_care;
  logic              rf_read_en;
  logic [IB-1:0]     rf_read_addr;
  logic [NC*DW-1:0]  rf_read_data;
  logic              busy;
  logic              done;
  logic [NC-1:0]     pass;
  logic [NC*(IB+1)-1:0] fail_count;
  logic [NC*IB-1:0]  first_fail;

  logic [DW-1:0] core_regs [NC][NR];

  int checks = 0;
  int errors = 0;

  reg_test_checker #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .IDX_BITS (IB), .NUM_CORES (NC), .LEN_BITS (LB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .test_length  (test_length),
    .halt_in      (halt_in),
    .exp_we       (exp_we),
    .exp_addr     (exp_addr),
    .exp_data     (exp_data),
    .exp_care     (exp_care),
    .rf_read_en   (rf_read_en),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_count   (fail_count),
    .first_fail   (first_fail)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_read_en) begin
      rf_read_data <= {core_regs[1][rf_read_addr], core_regs[0][rf_read_addr]};
    end
  end

  task automatic clear_cores();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) core_regs[c][r] = '0;
    end
  endtask

  task automatic write_exp(input int addr, input logic [DW-1:0] data, input logic care);
    exp_we   = 1'b1;
    exp_addr = IB'(addr);
    exp_data = data;
    exp_care = care;
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  // Pulses start across one posedge (cycle 0); returns at the negedge of cycle 1.
  task automatic pulse_start(input int len);
    start       = 1'b1;
    test_length = LB'(len);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, rf_read_en} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {busy, done, rf_read_en});
    end
    checks++;
    if ({rf_read_addr, pass, fail_count, first_fail} !== '0) begin
      errors++; $display("FAIL reset_results got addr=%0d pass=%b fc=%h ff=%h want all 0",
                         rf_read_addr, pass, fail_count, first_fail);
    end
  endtask

  task automatic test_defaults();
    int cyc;
    clear_cores();
    pulse_start(10);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL defaults_busy got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 45) begin errors++; $display("FAIL defaults_latency got %0d want 45", cyc); end
    checks++;
    if (pass !== 2'b11 || fail_count !== '0) begin
      errors++; $display("FAIL defaults_result got pass=%b fc=%h want 11 000", pass, fail_count);
    end
  endtask

  task automatic test_slti_mismatch();
    int cyc;
    write_exp(11, 32'h0000_1000, 1'b1);
    write_exp(12, 32'h8000_0000, 1'b1);
    write_exp(13, 32'hffff_f000, 1'b1);
    write_exp(14, 32'h1, 1'b1);
    write_exp(15, 32'h1, 1'b1);
    write_exp(17, 32'h1, 1'b1);
    for (int c = 0; c < NC; c++) begin
      core_regs[c][11] = 32'h0000_1000;
      core_regs[c][12] = 32'h8000_0000;
      core_regs[c][13] = 32'hffff_f000;
      core_regs[c][14] = 32'h1;
      core_regs[c][15] = 32'h0;
      core_regs[c][17] = 32'h1;
    end
    pulse_start(3);
    wait_done(1, cyc);
    checks++;
    if (cyc != 38) begin errors++; $display("FAIL slti_latency got %0d want 38", cyc); end
    checks++;
    if (pass !== 2'b00) begin errors++; $display("FAIL slti_pass got %b want 00", pass); end
    checks++;
    if (fail_count !== {6'd1, 6'd1}) begin
      errors++; $display("FAIL slti_count got %h want %h", fail_count, {6'd1, 6'd1});
    end
    checks++;
    if (first_fail !== {5'd15, 5'd15}) begin
      errors++; $display("FAIL slti_first got %h want %h", first_fail, {5'd15, 5'd15});
    end
  endtask

  task automatic test_dont_care();
    int cyc;
    write_exp(15, 32'h1, 1'b0);
    pulse_start(2);
    checks++;
    if (done !== 1'b0 || fail_count !== '0 || first_fail !== '0) begin
      errors++; $display("FAIL restart_clear got done=%b fc=%h ff=%h want 0 0 0",
                         done, fail_count, first_fail);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 37 || pass !== 2'b11) begin
      errors++; $display("FAIL dont_care got cyc=%0d pass=%b want 37 11", cyc, pass);
    end
  endtask

  task automatic test_halt();
    int cyc;
    pulse_start(100);
    repeat (4) @(negedge clock);
    checks++;
    if (rf_read_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL halt_wait got en=%b busy=%b want 0 1", rf_read_en, busy);
    end
    halt_in = 1'b1;
    @(negedge clock);
    halt_in = 1'b0;
    checks++;
    if (rf_read_en !== 1'b1 || rf_read_addr !== 5'd0) begin
      errors++; $display("FAIL halt_scan got en=%b addr=%0d want 1 0", rf_read_en, rf_read_addr);
    end
    wait_done(6, cyc);
    checks++;
    if (cyc != 39 || pass !== 2'b11) begin
      errors++; $display("FAIL halt_done got cyc=%0d pass=%b want 39 11", cyc, pass);
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    write_exp(15, 32'h1, 1'b1);
    pulse_start(0);
    repeat (4) @(negedge clock);
    start    = 1'b1;
    exp_we   = 1'b1;
    exp_addr = 5'd15;
    exp_data = 32'h0;
    exp_care = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    exp_we = 1'b0;
    wait_done(6, cyc);
    checks++;
    if (cyc != 35) begin errors++; $display("FAIL busy_start got %0d want 35", cyc); end
    checks++;
    if (pass !== 2'b00 || fail_count !== {6'd1, 6'd1} || first_fail !== {5'd15, 5'd15}) begin
      errors++; $display("FAIL busy_write got pass=%b fc=%h ff=%h want 00 041 1ef",
                         pass, fail_count, first_fail);
    end
    pulse_start(0);
    repeat (8) @(negedge clock);
    checks++;
    if (rf_read_addr !== 5'd7) begin
      errors++; $display("FAIL abort_pos got %0d want 7", rf_read_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, rf_read_en, rf_read_addr, pass, fail_count, first_fail} !== '0) begin
      errors++; $display("FAIL abort_reset got busy=%b done=%b en=%b fc=%h ff=%h want all 0",
                         busy, done, rf_read_en, fail_count, first_fail);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_same_cycle_write();
    int cyc;
    clear_cores();
    exp_we   = 1'b1;
    exp_addr = 5'd0;
    exp_data = 32'h1;
    exp_care = 1'b1;
    pulse_start(1);
    exp_we = 1'b0;
    wait_done(1, cyc);
    checks++;
    if (cyc != 36 || pass !== 2'b00 || fail_count !== {6'd1, 6'd1} || first_fail !== '0) begin
      errors++; $display("FAIL same_cycle got cyc=%0d pass=%b fc=%h ff=%h want 36 00 041 000",
                         cyc, pass, fail_count, first_fail);
    end
  endtask

  task automatic test_two_cores();
    int cyc;
    write_exp(0, 32'h0, 1'b1);
    clear_cores();
    core_regs[1][3]  = 32'h5;
    core_regs[1][20] = 32'h7;
    pulse_start(4);
    wait_done(1, cyc);
    checks++;
    if (pass !== 2'b01) begin errors++; $display("FAIL cores_pass got %b want 01", pass); end
    checks++;
    if (fail_count[11:6] !== 6'd2 || fail_count[5:0] !== 6'd0) begin
      errors++; $display("FAIL cores_count got %h want 080", fail_count);
    end
    checks++;
    if (first_fail[9:5] !== 5'd3 || first_fail[4:0] !== 5'd0) begin
      errors++; $display("FAIL cores_first got %h want 060", first_fail);
    end
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    test_length = '0;
    halt_in     = 1'b0;
    exp_we      = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    exp_care    = 1'b1;
    rf_read_data = '0;
    clear_cores();
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_defaults();
    test_slti_mismatch();
    test_dont_care();
    test_halt();
    test_ignore_busy();
    test_same_cycle_write();
    test_two_cores();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
